// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// The sequencer side is the master; the datapath side drives opcode and mem_ready.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_w;
  logic             pc_w;
  logic             pc_w_cond;
  logic             pc_src;
  logic             alu_src;
  logic             alu_a_pc;
  logic [1:0]       alu_op;
  logic             reg_w;
  logic             mem_reg;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_w, pc_w, pc_w_cond, pc_src,
           alu_src, alu_a_pc, alu_op, reg_w, mem_reg, illegal, instret, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_w, pc_w, pc_w_cond, pc_src,
           alu_src, alu_a_pc, alu_op, reg_w, mem_reg, illegal, instret, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch/decode/execute
// states over a shared memory port and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_ADDR   = 4'd4,
    S_MEMRD  = 4'd5,
    S_LDWB   = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_ITYPE, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_OTHER
  } cls_t;

  state_t           state_reg, state_next;
  cls_t             cls_reg, cls_dec;
  logic [CNT_W-1:0] instret_reg;

  logic       retire;
  logic       mem_req, mem_we, iord, ir_w, pc_w, pc_w_cond, pc_src;
  logic       alu_src, alu_a_pc, reg_w, mem_reg;
  logic [1:0] alu_op;

  always_comb begin
    case (bus.opcode)
      7'b0110011: cls_dec = C_RTYPE;
      7'b0010011: cls_dec = C_ITYPE;
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1101111: cls_dec = C_JAL;
      default:    cls_dec = C_OTHER;
    endcase
  end

  // The class is captured once in DECODE so later states are immune to IR changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      cls_reg     <= C_OTHER;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) cls_reg <= cls_dec;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    pc_w_cond  = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_a_pc   = 1'b0;
    alu_op     = 2'b00;
    reg_w      = 1'b0;
    mem_reg    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls_dec)
          C_RTYPE, C_ITYPE, C_LUI, C_AUIPC: state_next = S_EXEC;
          C_LOAD, C_STORE:                  state_next = S_ADDR;
          C_BRANCH:                         state_next = S_BRANCH;
          C_JAL:                            state_next = S_JAL;
          default:                          state_next = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (cls_reg)
          C_RTYPE: alu_op = 2'b10;
          C_ITYPE: begin alu_op = 2'b11; alu_src = 1'b1; end
          C_AUIPC: begin alu_src = 1'b1; alu_a_pc = 1'b1; end
          default: alu_src = 1'b1;
        endcase
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDR: begin
        alu_src    = 1'b1;
        state_next = (cls_reg == C_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) state_next = S_LDWB;
      end
      S_LDWB: begin
        reg_w      = 1'b1;
        mem_reg    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_op     = 2'b01;
        pc_w_cond  = 1'b1;
        pc_src     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        reg_w      = 1'b1;
        pc_w       = 1'b1;
        pc_src     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high, so an in-flight request drops immediately.
  assign bus.mem_req   = mem_req & ~rst;
  assign bus.mem_we    = mem_we & ~rst;
  assign bus.iord      = iord & ~rst;
  assign bus.ir_w      = ir_w & ~rst;
  assign bus.pc_w      = pc_w & ~rst;
  assign bus.pc_w_cond = pc_w_cond & ~rst;
  assign bus.pc_src    = pc_src & ~rst;
  assign bus.alu_src   = alu_src & ~rst;
  assign bus.alu_a_pc  = alu_a_pc & ~rst;
  assign bus.alu_op    = rst ? 2'b00 : alu_op;
  assign bus.reg_w     = reg_w & ~rst;
  assign bus.mem_reg   = mem_reg & ~rst;
  assign bus.illegal   = (state_reg == S_TRAP) & ~rst;
  assign bus.instret   = rst ? '0 : instret_reg;
  assign bus.state     = rst ? 4'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction's expected state path and
// strobe totals are derived from its opcode and the memory wait counts.
module tb_multicycle_ctrl;
  localparam int CW = 4;  // narrow counter so the random run wraps it

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 2ms", $time);
    $fatal(1, "watchdog");
  end

  // 0 R, 1 I, 2 LUI, 3 AUIPC, 4 load, 5 store, 6 branch, 7 JAL, 8 unsupported
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0110111: return 2;
      7'b0010111: return 3;
      7'b0000011: return 4;
      7'b0100011: return 5;
      7'b1100011: return 6;
      7'b1101111: return 7;
      default:    return 8;
    endcase
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 7'd0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one legal instruction with fw fetch waits and mw data waits, checking the state path
  // every cycle and the strobe totals, key-cycle ALU controls and instret afterwards.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input string tag);
    int seq[$];
    int c, k, n, fc, mc;
    int rw, we, irw, pcw, pcc, psrc, req, io;
    logic [1:0] k_op;
    logic k_src, k_apc, k_psrc, l_rw, l_mr;
    int e_rw, e_we, e_pcw, e_pcc, e_psrc, e_req, e_io;
    logic [1:0] e_op;
    logic e_src, e_apc, e_mr;
    c = cls_of(opc);
    seq.delete();
    for (int i = 0; i <= fw; i++) seq.push_back(0);
    seq.push_back(1);
    if (c <= 3) begin seq.push_back(2); seq.push_back(3); end
    else if (c == 4) begin
      seq.push_back(4);
      for (int i = 0; i <= mw; i++) seq.push_back(5);
      seq.push_back(6);
    end else if (c == 5) begin
      seq.push_back(4);
      for (int i = 0; i <= mw; i++) seq.push_back(7);
    end else if (c == 6) seq.push_back(8);
    else seq.push_back(9);
    n = seq.size();
    k = fw + 2;
    fc = 0; mc = 0;
    rw = 0; we = 0; irw = 0; pcw = 0; pcc = 0; psrc = 0; req = 0; io = 0;
    k_op = 2'b00; k_src = 1'b0; k_apc = 1'b0; k_psrc = 1'b0; l_rw = 1'b0; l_mr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.iord) begin bus.mem_ready = (fc == fw); fc++; end
      else if (bus.mem_req) begin bus.mem_ready = (mc == mw); mc++; end
      else bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode = (i == fw + 1) ? opc : 7'($urandom);
      #1;
      n_cmp++;
      if (bus.state !== 4'(seq[i])) begin
        n_bad++;
        $display("FAIL %s state cyc %0d: got %0d expected %0d", tag, i, bus.state, seq[i]);
      end
      rw += int'(bus.reg_w); we += int'(bus.mem_we); irw += int'(bus.ir_w);
      pcw += int'(bus.pc_w); pcc += int'(bus.pc_w_cond); psrc += int'(bus.pc_src);
      req += int'(bus.mem_req); io += int'(bus.iord);
      if (i == k) begin
        k_op = bus.alu_op; k_src = bus.alu_src; k_apc = bus.alu_a_pc; k_psrc = bus.pc_src;
      end
      if (i == n - 1) begin l_rw = bus.reg_w; l_mr = bus.mem_reg; end
    end
    @(posedge clk);
    #1;
    e_rw   = (c <= 4 || c == 7) ? 1 : 0;
    e_we   = (c == 5) ? mw + 1 : 0;
    e_io   = (c == 4 || c == 5) ? mw + 1 : 0;
    e_req  = fw + 1 + e_io;
    e_pcw  = (c == 7) ? 2 : 1;
    e_pcc  = (c == 6) ? 1 : 0;
    e_psrc = (c >= 6) ? 1 : 0;
    e_mr   = (c == 4);
    e_apc  = (c == 3);
    e_src  = (c >= 1 && c <= 5);
    e_op   = (c == 0) ? 2'b10 : (c == 1) ? 2'b11 : (c == 6) ? 2'b01 : 2'b00;
    exp_instret = (exp_instret + 1) % (1 << CW);
    n_cmp += 6;
    if (rw !== e_rw || l_rw !== (e_rw == 1)) begin
      n_bad++; $display("FAIL %s reg_w: cycles %0d last %0b expected %0d on last", tag, rw, l_rw, e_rw);
    end
    if (we !== e_we || io !== e_io || req !== e_req) begin
      n_bad++; $display("FAIL %s mem strobes: req/iord/we %0d/%0d/%0d expected %0d/%0d/%0d",
                        tag, req, io, we, e_req, e_io, e_we);
    end
    if (irw !== 1 || pcw !== e_pcw || pcc !== e_pcc || psrc !== e_psrc) begin
      n_bad++; $display("FAIL %s pc/ir: ir_w/pc_w/pc_w_cond/pc_src %0d/%0d/%0d/%0d expected 1/%0d/%0d/%0d",
                        tag, irw, pcw, pcc, psrc, e_pcw, e_pcc, e_psrc);
    end
    if (k_op !== e_op || k_src !== e_src || k_apc !== e_apc || k_psrc !== (e_psrc == 1)) begin
      n_bad++; $display("FAIL %s alu ctl: op/src/a_pc/pc_src %b/%b/%b/%b expected %b/%b/%b/%0d",
                        tag, k_op, k_src, k_apc, k_psrc, e_op, e_src, e_apc, e_psrc);
    end
    if (l_mr !== e_mr) begin
      n_bad++; $display("FAIL %s mem_reg at writeback: got %b expected %b", tag, l_mr, e_mr);
    end
    if (bus.instret !== CW'(exp_instret) || bus.state !== 4'd0) begin
      n_bad++; $display("FAIL %s retire: instret %0d state %0d expected %0d state 0",
                        tag, bus.instret, bus.state, exp_instret);
    end
    $display("%s opc=%b fw=%0d mw=%0d cycles=%0d instret=%0d", tag, opc, fw, mw, n, bus.instret);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 7'b1111111;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.iord, bus.ir_w, bus.pc_w, bus.pc_w_cond, bus.pc_src,
           bus.alu_src, bus.alu_a_pc, bus.alu_op, bus.reg_w, bus.mem_reg, bus.illegal,
           bus.instret, bus.state} !== '0) begin
        n_bad++; $display("FAIL reset outputs: mem_req %b state %0d instret %0d expected all 0",
                          bus.mem_req, bus.state, bus.instret);
      end
    end
    do_reset(1);
    exp_instret = 0;
    n_cmp++;
    if (bus.state !== 4'd0 || bus.mem_req !== 1'b1 || bus.iord !== 1'b0 || bus.instret !== '0) begin
      n_bad++; $display("FAIL reset release: state %0d mem_req %b iord %b instret %0d expected 0/1/0/0",
                        bus.state, bus.mem_req, bus.iord, bus.instret);
    end
    $display("reset: state=%0d mem_req=%b", bus.state, bus.mem_req);
  endtask

  task automatic test_r_type();
    run_instr(7'b0110011, 0, 0, "rtype");
  endtask

  task automatic test_load_wait();
    run_instr(7'b0000011, 0, 3, "load_wait");
  endtask

  task automatic test_store();
    run_instr(7'b0100011, 1, 2, "store");
  endtask

  task automatic test_branch_jal();
    run_instr(7'b1100011, 0, 0, "branch");
    run_instr(7'b1101111, 0, 0, "jal");
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal [8];
    legal = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
              7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    for (int i = 0; i < 40; i++)
      run_instr(legal[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), "rand");
  endtask

  task automatic test_reset_midaccess();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_ready = (i == 0);
      bus.opcode = (i == 1) ? 7'b0000011 : 7'($urandom);
      #1;
    end
    n_cmp++;
    if (bus.state !== 4'd5 || bus.mem_req !== 1'b1 || bus.iord !== 1'b1 ||
        bus.instret !== CW'(exp_instret)) begin
      n_bad++; $display("FAIL midaccess wait: state %0d req %b iord %b instret %0d expected 5/1/1/%0d",
                        bus.state, bus.mem_req, bus.iord, bus.instret, exp_instret);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.state !== 4'd0 || bus.instret !== '0) begin
      n_bad++; $display("FAIL midaccess rst: mem_req %b state %0d instret %0d expected 0/0/0",
                        bus.mem_req, bus.state, bus.instret);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    exp_instret = 0;
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.iord !== 1'b0 || bus.state !== 4'd0 || bus.instret !== '0) begin
      n_bad++; $display("FAIL midaccess release: mem_req %b iord %b state %0d instret %0d expected 1/0/0/0",
                        bus.mem_req, bus.iord, bus.state, bus.instret);
    end
    @(posedge clk);
    #1;
    $display("reset_midaccess: state=%0d instret=%0d", bus.state, bus.instret);
  endtask

  task automatic test_trap();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus.mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.opcode = (i == 1) ? 7'b1111111 : 7'($urandom);
      #1;
      if (i >= 2) begin
        n_cmp++;
        if (bus.state !== 4'd10 || bus.illegal !== 1'b1 || bus.instret !== CW'(exp_instret) ||
            {bus.mem_req, bus.mem_we, bus.iord, bus.ir_w, bus.pc_w, bus.pc_w_cond, bus.pc_src,
             bus.alu_src, bus.alu_a_pc, bus.alu_op, bus.reg_w, bus.mem_reg} !== '0) begin
          n_bad++; $display("FAIL trap hold cyc %0d: state %0d illegal %b instret %0d req %b expected 10/1/%0d/0",
                            i, bus.state, bus.illegal, bus.instret, bus.mem_req, exp_instret);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.illegal !== 1'b0 || bus.state !== 4'd0 || bus.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL trap rst: illegal %b state %0d mem_req %b expected 0/0/0",
                        bus.illegal, bus.state, bus.mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_instret = 0;
    n_cmp++;
    if (bus.illegal !== 1'b0 || bus.state !== 4'd0 || bus.mem_req !== 1'b1 || bus.instret !== '0) begin
      n_bad++; $display("FAIL trap recover: illegal %b state %0d mem_req %b instret %0d expected 0/0/1/0",
                        bus.illegal, bus.state, bus.mem_req, bus.instret);
    end
    $display("trap: illegal=%b state=%0d after reset pulse", bus.illegal, bus.state);
    run_instr(7'b0010011, 0, 0, "after_trap");
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode = 7'd0;
    test_reset();
    test_r_type();
    test_load_wait();
    test_store();
    test_branch_jal();
    test_back_to_back();
    test_reset_midaccess();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath: replaces the single-cycle opcode decoder with a state machine that drives one shared instruction/data memory port, the IR, PC, register file and ALU over several cycles per instruction. Sits beside the datapath, takes the current IR opcode and a memory-ready handshake, and emits per-cycle control strobes plus a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- opcode  input  7  IR[6:0]; valid from the DECODE cycle onward
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request
- mem_we  output  1  write strobe, only with mem_req
- iord  output  1  0 = address from PC (fetch), 1 = address from ALU result (data)
- ir_w  output  1  load IR from memory read data
- pc_w  output  1  unconditional PC write
- pc_w_cond  output  1  PC write if branch compare true
- pc_src  output  1  0 = PC+4, 1 = ALU target
- alu_src  output  1  0 = rs2, 1 = immediate
- alu_a_pc  output  1  ALU operand A = PC instead of rs1
- alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- reg_w  output  1  register file write
- mem_reg  output  1  writeback source: 1 = memory data, 0 = ALU
- illegal  output  1  sticky unsupported-opcode flag
- instret  output  CNT_W  instructions retired since reset
- state  output  4  current state, for debug

## Operation
- States/encoding: FETCH 0, DECODE 1, EXEC 2, ALUWB 3, ADDR 4, MEMRD 5, LDWB 6, MEMWR 7, BRANCH 8, JAL 9, TRAP 10. Unused codes go to FETCH.
- Opcode class latched into an internal register in DECODE; later states never read `opcode`.
- FETCH: mem_req=1, iord=0. Stays while mem_ready=0. On mem_ready=1: ir_w=1, pc_w=1, pc_src=0, next DECODE.
- DECODE: no strobes. 0110011/0010011/0110111/0010111 -> EXEC; 0000011/0100011 -> ADDR; 1100011 -> BRANCH; 1101111 -> JAL; any other -> TRAP.
- EXEC: R-type alu_op=10, alu_src=0; I-type alu_op=11, alu_src=1; LUI alu_op=00, alu_src=1 (datapath zeros A for LUI); AUIPC alu_op=00, alu_src=1, alu_a_pc=1. Next ALUWB.
- ALUWB: reg_w=1, mem_reg=0; retires; next FETCH.
- ADDR: alu_op=00, alu_src=1; load -> MEMRD, store -> MEMWR.
- MEMRD: mem_req=1, iord=1; hold until mem_ready; then LDWB.
- LDWB: reg_w=1, mem_reg=1; retires; next FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; hold until mem_ready; retires on mem_ready; next FETCH.
- BRANCH: alu_op=01, alu_src=0, pc_w_cond=1, pc_src=1; retires; next FETCH.
- JAL: reg_w=1, mem_reg=0, pc_w=1, pc_src=1; retires; next FETCH.
- TRAP: illegal set, all strobes 0, state held until reset; instret frozen.
- instret increments by 1 on each retiring edge; wraps modulo 2^CNT_W.
- Strobes not listed for a state are 0.

## Timing
- Outputs are combinational from registered state (plus mem_ready in FETCH/MEMWR for ir_w/pc_w/retire); no input-to-output path except through mem_ready.
- Cycles with zero-wait memory: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 3. Each wait cycle adds 1.
- While rst=1: all outputs 0 (including mem_req), illegal 0, instret 0. First cycle after rst falls: state FETCH, mem_req=1.
- Reset mid-access: the request is abandoned; mem_req drops in the cycle rst is high; no retire counted.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- mem_req stays high continuously through wait cycles; address/we must not change until mem_ready.

## Test plan
- Reset then R-type 0110011, mem_ready tied 1 -> states 0,1,2,3,0; reg_w only in cycle 4; instret 0 -> 1.
- Load 0000011 with 3 wait cycles in MEMRD -> mem_req,iord held 4 cycles; LDWB reg_w=1,mem_reg=1; total 8 cycles.
- Store 0100011 -> MEMWR mem_we=1, reg_w never asserted; instret +1 on mem_ready edge.
- Branch then JAL -> BRANCH pc_w_cond=1,pc_src=1; JAL pc_w=1,reg_w=1; each 3 cycles.
- Opcode 1111111 -> TRAP, illegal=1 held 20 cycles, no strobes; rst pulse -> illegal 0, FETCH.
- rst asserted during MEMRD wait -> next cycle mem_req 0, state 0, instret unchanged-to-0.
